// File: rtl/bcd_alu_seq.sv
// Digit-serial BCD add/subtract unit: one digit per clock, LSD first, with
// start/busy/done handshake and negative/overflow/error flags.
module bcd_alu_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  start,
  input  logic [1:0]            op_selected,
  input  logic [4*DIGITS-1:0]   bcd1,
  input  logic [4*DIGITS-1:0]   bcd2,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  special_signal,
  output logic                  overflow,
  output logic                  error
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]     op_q, op_d;
  logic           cy_q, cy_d, neg_q, neg_d, err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [W-1:0]   bcd_out_q, bcd_out_d;
  logic           special_q, special_d, overflow_q, overflow_d, error_q, error_d;

  logic           digit_bad_c;
  logic [3:0]     dig_c;
  logic           cy_next_c;
  logic [4:0]     sum_c, sub_c;

  assign busy           = busy_q;
  assign done           = done_q;
  assign bcd_out        = bcd_out_q;
  assign special_signal = special_q;
  assign overflow       = overflow_q;
  assign error          = error_q;

  // Flag any latched operand digit outside 0..9
  always_comb begin
    digit_bad_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9) digit_bad_c = 1'b1;
    end
  end

  // Current-digit add/subtract with BCD correction on the low digits of A/B
  always_comb begin
    sum_c     = 5'(a_q[3:0]) + 5'(b_q[3:0]) + 5'(cy_q);
    sub_c     = 5'(b_q[3:0]) + 5'(cy_q);
    dig_c     = 4'd0;
    cy_next_c = 1'b0;
    if (op_q == OP_ADD) begin
      if (sum_c > 5'd9) begin
        dig_c     = 4'(sum_c + 5'd6);
        cy_next_c = 1'b1;
      end else begin
        dig_c     = 4'(sum_c);
      end
    end else begin
      if (5'(a_q[3:0]) < sub_c) begin
        dig_c     = 4'(5'(a_q[3:0]) + 5'd10 - sub_c);
        cy_next_c = 1'b1;
      end else begin
        dig_c     = 4'(5'(a_q[3:0]) - sub_c);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    cy_d       = cy_q;
    neg_d      = neg_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    bcd_out_d  = bcd_out_q;
    special_d  = special_q;
    overflow_d = overflow_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = bcd1;
          b_d     = bcd2;
          op_d    = op_selected;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        cy_d  = 1'b0;
        neg_d = 1'b0;
        err_d = 1'b0;
        if (digit_bad_c || (op_q != OP_ADD && op_q != OP_SUB)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          // Packed BCD with valid digits orders the same as its numeric value
          if (op_q == OP_SUB && a_q < b_q) begin
            a_d   = b_q;
            b_d   = a_q;
            neg_d = 1'b1;
          end
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        res_d = W'({dig_c, res_q} >> 4);
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        cy_d  = cy_next_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        done_d     = 1'b1;
        bcd_out_d  = err_q ? '0 : res_q;
        special_d  = ~err_q & neg_q;
        overflow_d = ~err_q & (op_q == OP_ADD) & cy_q;
        error_d    = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 2'b00;
      res_q      <= '0;
      cy_q       <= 1'b0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_out_q  <= '0;
      special_q  <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      cy_q       <= cy_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_out_q  <= bcd_out_d;
      special_q  <= special_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Self-checking bench for bcd_alu_seq (DIGITS=4 and DIGITS=6 instances).
module tb_bcd_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear_n;
  logic        start4, busy4, done4, neg4, ovf4, err4;
  logic [1:0]  op4;
  logic [15:0] a4, b4, out4;
  logic        start6, busy6, done6, neg6, ovf6, err6;
  logic [1:0]  op6;
  logic [23:0] a6, b6, out6;

  int assertions = 0;
  int failures   = 0;

  typedef struct packed {
    logic [23:0] out;
    logic        neg;
    logic        ovf;
    logic        err;
  } res_t;

  bcd_alu_seq #(.DIGITS(4)) dut4 (
    .clk(clk), .clear_n(clear_n), .start(start4), .op_selected(op4),
    .bcd1(a4), .bcd2(b4), .busy(busy4), .done(done4), .bcd_out(out4),
    .special_signal(neg4), .overflow(ovf4), .error(err4)
  );

  bcd_alu_seq #(.DIGITS(6)) dut6 (
    .clk(clk), .clear_n(clear_n), .start(start6), .op_selected(op6),
    .bcd1(a6), .bcd2(b6), .busy(busy6), .done(done6), .bcd_out(out6),
    .special_signal(neg6), .overflow(ovf6), .error(err6)
  );

  // ---------------- reference model (plain decimal arithmetic) ----------------
  function automatic int bcd2int(input logic [23:0] v, input int nd);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [23:0] int2bcd(input int x, input int nd);
    logic [23:0] r = '0;
    int y = x;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  function automatic res_t model(input int nd, input logic [1:0] op,
                                 input logic [23:0] a, input logic [23:0] b);
    res_t r;
    int va, vb, lim, s;
    r = '0;
    r.err = !(op == 2'b01 || op == 2'b10);
    for (int i = 0; i < nd; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) r.err = 1'b1;
    if (r.err) return r;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    va = bcd2int(a, nd);
    vb = bcd2int(b, nd);
    if (op == 2'b01) begin
      s = va + vb;
      r.ovf = (s >= lim);
      r.out = int2bcd(s % lim, nd);
    end else if (va >= vb) begin
      r.out = int2bcd(va - vb, nd);
    end else begin
      r.out = int2bcd(vb - va, nd);
      r.neg = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [23:0] rand_bcd(input int nd);
    logic [23:0] r = '0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  // Launch one op on the 4-digit unit; report latency and outputs at done
  task automatic drive4(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [15:0] out, output logic neg,
                        output logic ovf, output logic err, output logic busy_mid);
    @(negedge clk);
    op4 = op; a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    busy_mid = busy4;
    a4 = 16'($urandom); b4 = 16'($urandom); op4 = 2'($urandom);
    lat = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    out = out4; neg = neg4; ovf = ovf4; err = err4;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    clear_n = 1'b0;
    start4 = 1'b0; op4 = 2'b01; a4 = 16'h1234; b4 = 16'h5678;
    start6 = 1'b0; op6 = 2'b01; a6 = 24'h0; b6 = 24'h0;
    repeat (3) @(negedge clk);
    assertions++;
    if ({busy4, done4, out4, neg4, ovf4, err4} !== 21'h0) begin
      failures++;
      $display("FAIL reset4: got %h expected 0", {busy4, done4, out4, neg4, ovf4, err4});
    end
    assertions++;
    if ({busy6, done6, out6, neg6, ovf6, err6} !== 29'h0) begin
      failures++;
      $display("FAIL reset6: got %h expected 0", {busy6, done6, out6, neg6, ovf6, err6});
    end
    clear_n = 1'b1;
    repeat (3) @(negedge clk);
    assertions++;
    if ({busy4, done4, out4, neg4, ovf4, err4} !== 21'h0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h expected 0", {busy4, done4, out4, neg4, ovf4, err4});
    end
  endtask

  task automatic test_add;
    logic [15:0] va [3] = '{16'h1234, 16'h9999, 16'h0458};
    logic [15:0] vb [3] = '{16'h8765, 16'h0001, 16'h0367};
    logic [15:0] a, b, out;
    logic neg, ovf, err, bm;
    int lat;
    res_t r;
    for (int k = 0; k < 23; k++) begin
      if (k < 3) begin a = va[k]; b = vb[k]; end
      else begin a = rand_bcd(4)[15:0]; b = rand_bcd(4)[15:0]; end
      r = model(4, 2'b01, {8'h0, a}, {8'h0, b});
      drive4(2'b01, a, b, lat, out, neg, ovf, err, bm);
      assertions++;
      if ({lat, out, neg, ovf, err, bm} !== {32'd6, r.out[15:0], r.neg, r.ovf, r.err, 1'b1}) begin
        failures++;
        $display("FAIL add %h+%h: got lat=%0d out=%h n=%b o=%b e=%b busy=%b expected lat=6 out=%h n=%b o=%b e=%b busy=1",
                 a, b, lat, out, neg, ovf, err, bm, r.out[15:0], r.neg, r.ovf, r.err);
      end
    end
  endtask

  task automatic test_sub;
    logic [15:0] va [3] = '{16'h0100, 16'h0250, 16'h9000};
    logic [15:0] vb [3] = '{16'h0250, 16'h0250, 16'h0001};
    logic [15:0] a, b, out;
    logic neg, ovf, err, bm;
    int lat;
    res_t r;
    for (int k = 0; k < 23; k++) begin
      if (k < 3) begin a = va[k]; b = vb[k]; end
      else begin a = rand_bcd(4)[15:0]; b = rand_bcd(4)[15:0]; end
      r = model(4, 2'b10, {8'h0, a}, {8'h0, b});
      drive4(2'b10, a, b, lat, out, neg, ovf, err, bm);
      assertions++;
      if ({lat, out, neg, ovf, err, bm} !== {32'd6, r.out[15:0], r.neg, r.ovf, r.err, 1'b1}) begin
        failures++;
        $display("FAIL sub %h-%h: got lat=%0d out=%h n=%b o=%b e=%b busy=%b expected lat=6 out=%h n=%b o=%b e=%b busy=1",
                 a, b, lat, out, neg, ovf, err, bm, r.out[15:0], r.neg, r.ovf, r.err);
      end
    end
  endtask

  task automatic test_error;
    logic [15:0] a, b, out;
    logic [1:0] op;
    logic neg, ovf, err, bm;
    int lat, pos;
    res_t r;
    for (int k = 0; k < 12; k++) begin
      a = rand_bcd(4)[15:0];
      b = rand_bcd(4)[15:0];
      op = 2'($urandom_range(2, 1));
      case (k)
        0: begin a = 16'h12A4; b = 16'h0001; op = 2'b01; end
        1: begin a = 16'h1234; b = 16'h0001; op = 2'b11; end
        2: begin a = 16'h1234; b = 16'h0001; op = 2'b00; end
        default: begin
          pos = int'($urandom_range(3, 0));
          if (k % 2 == 0) a[4*pos +: 4] = 4'($urandom_range(15, 10));
          else            b[4*pos +: 4] = 4'($urandom_range(15, 10));
        end
      endcase
      r = model(4, op, {8'h0, a}, {8'h0, b});
      drive4(op, a, b, lat, out, neg, ovf, err, bm);
      assertions++;
      if ({lat, out, neg, ovf, err, bm} !== {32'd2, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1} || r.err !== 1'b1) begin
        failures++;
        $display("FAIL error op=%b %h,%h: got lat=%0d out=%h n=%b o=%b e=%b busy=%b expected lat=2 out=0000 n=0 o=0 e=1 busy=1",
                 op, a, b, lat, out, neg, ovf, err, bm);
      end
    end
  endtask

  task automatic test_start_ignored;
    int ndone;
    logic [15:0] out_first;
    logic flags_first;
    // start held high until done is seen
    @(negedge clk);
    op4 = 2'b01; a4 = 16'h0458; b4 = 16'h0367; start4 = 1'b1;
    ndone = 0; out_first = 16'hxxxx; flags_first = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        ndone++;
        start4 = 1'b0;
        if (ndone == 1) begin out_first = out4; flags_first = neg4 | ovf4 | err4; end
      end
    end
    start4 = 1'b0;
    assertions++;
    if (ndone != 1 || out_first !== 16'h0825 || flags_first !== 1'b0) begin
      failures++;
      $display("FAIL start_held: got dones=%0d out=%h flags=%b expected dones=1 out=0825 flags=0",
               ndone, out_first, flags_first);
    end
    // single start pulse, then a second pulse mid-CALC with different operands
    @(negedge clk);
    op4 = 2'b10; a4 = 16'h0100; b4 = 16'h0250; start4 = 1'b1;
    ndone = 0; out_first = 16'hxxxx; flags_first = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start4 = (c == 3);
      a4 = 16'h9999; b4 = 16'h0001; op4 = 2'b01;
      if (done4 === 1'b1) begin
        ndone++;
        if (ndone == 1) begin out_first = out4; flags_first = neg4; end
      end
    end
    start4 = 1'b0;
    assertions++;
    if (ndone != 1 || out_first !== 16'h0150 || flags_first !== 1'b1) begin
      failures++;
      $display("FAIL start_mid_calc: got dones=%0d out=%h neg=%b expected dones=1 out=0150 neg=1",
               ndone, out_first, flags_first);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b, out;
    logic neg, ovf, err, bm;
    int lat;
    res_t r;
    // each new start is raised in the done-pulse cycle of the previous op
    for (int k = 0; k < 6; k++) begin
      a = rand_bcd(4)[15:0];
      b = rand_bcd(4)[15:0];
      r = model(4, 2'b01, {8'h0, a}, {8'h0, b});
      op4 = 2'b01; a4 = a; b4 = b; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      bm = busy4;
      lat = 0;
      while (done4 !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      out = out4; neg = neg4; ovf = ovf4; err = err4;
      assertions++;
      if ({lat, out, neg, ovf, err, bm} !== {32'd6, r.out[15:0], r.neg, r.ovf, r.err, 1'b1}) begin
        failures++;
        $display("FAIL back_to_back %0d %h+%h: got lat=%0d out=%h n=%b o=%b e=%b busy=%b expected lat=6 out=%h n=%b o=%b e=%b busy=1",
                 k, a, b, lat, out, neg, ovf, err, bm, r.out[15:0], r.neg, r.ovf, r.err);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [15:0] out;
    logic neg, ovf, err, bm;
    int lat, ndone;
    drive4(2'b01, 16'h1234, 16'h8765, lat, out, neg, ovf, err, bm);
    @(negedge clk);
    op4 = 2'b01; a4 = 16'h0458; b4 = 16'h0367; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    #1 clear_n = 1'b0;
    #1;
    assertions++;
    if ({busy4, done4, out4, neg4, ovf4, err4} !== 21'h0) begin
      failures++;
      $display("FAIL reset_abort_async: got %h expected 0", {busy4, done4, out4, neg4, ovf4, err4});
    end
    @(negedge clk);
    clear_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) ndone++;
    end
    assertions++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL reset_abort_no_done: got %0d active cycles expected 0", ndone);
    end
    drive4(2'b01, 16'h1234, 16'h8765, lat, out, neg, ovf, err, bm);
    assertions++;
    if ({lat, out, neg, ovf, err} !== {32'd6, 16'h9999, 3'b000}) begin
      failures++;
      $display("FAIL after_reset_op: got lat=%0d out=%h flags=%b%b%b expected lat=6 out=9999 flags=000",
               lat, out, neg, ovf, err);
    end
  endtask

  task automatic test_digits6;
    logic [23:0] a, b;
    logic [1:0] op;
    logic bm;
    int lat;
    res_t r;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin a = 24'h001234; b = 24'h008765; op = 2'b01; end
      else begin a = rand_bcd(6); b = rand_bcd(6); op = 2'($urandom_range(2, 1)); end
      r = model(6, op, a, b);
      @(negedge clk);
      op6 = op; a6 = a; b6 = b; start6 = 1'b1;
      @(negedge clk);
      start6 = 1'b0;
      bm = busy6;
      a6 = 24'($urandom);
      lat = 0;
      while (done6 !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      assertions++;
      if ({lat, out6, neg6, ovf6, err6, bm} !== {32'd8, r.out, r.neg, r.ovf, r.err, 1'b1}) begin
        failures++;
        $display("FAIL digits6 op=%b %h,%h: got lat=%0d out=%h n=%b o=%b e=%b busy=%b expected lat=8 out=%h n=%b o=%b e=%b busy=1",
                 op, a, b, lat, out6, neg6, ovf6, err6, bm, r.out, r.neg, r.ovf, r.err);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_error;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    test_digits6;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
